// File: rtl/mux_sequencer.sv
// Column-group multiplexer sequencer: one-hot mux enables with break-before-make dead time,
// advanced by column_ready and resynchronised to group 0 by position_sync.
module mux_sequencer #(
  parameter int unsigned NB_MUX      = 8,
  parameter int unsigned DEAD_CYCLES = 4,
  parameter int unsigned IDX_W       = $clog2(NB_MUX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              position_sync,
  input  logic              column_ready,
  output logic [NB_MUX-1:0] mux_out,
  output logic [IDX_W-1:0]  mux_index,
  output logic              slice_done,
  output logic              overrun
);

  localparam int unsigned CNT_W = $clog2(DEAD_CYCLES + 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
  localparam logic [1:0] ST_DEAD      = 2'd2;
  localparam logic [1:0] ST_ON        = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NB_MUX - 1);

  logic [1:0]        state_q,   state_d;
  logic [IDX_W-1:0]  index_q,   index_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [NB_MUX-1:0] mux_q,     mux_d;
  logic              slice_q,   slice_d;
  logic              overrun_q, overrun_d;

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      cnt_q     <= '0;
      mux_q     <= '0;
      slice_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      cnt_q     <= cnt_d;
      mux_q     <= mux_d;
      slice_q   <= slice_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic; enable low overrides everything, position_sync beats column_ready
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    cnt_d     = cnt_q;
    slice_d   = 1'b0;
    overrun_d = overrun_q;

    if (!enable) begin
      state_d   = ST_IDLE;
      index_d   = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_SYNC;
          index_d = '0;
        end
        ST_WAIT_SYNC: begin
          if (position_sync) begin
            state_d = ST_DEAD;
            index_d = '0;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_DEAD: begin
          if (column_ready) overrun_d = 1'b1;
          if (position_sync) begin
            index_d = '0;
            cnt_d   = CNT_LOAD;
          end else if (cnt_q == '0) begin
            state_d = ST_ON;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_ON: begin
          if (position_sync) begin
            state_d = ST_DEAD;
            index_d = '0;
            cnt_d   = CNT_LOAD;
          end else if (column_ready) begin
            state_d = ST_DEAD;
            cnt_d   = CNT_LOAD;
            if (index_q == IDX_LAST) begin
              index_d = '0;
              slice_d = 1'b1;
            end else begin
              index_d = index_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          index_d = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Registered decode keeps mux_out a pure flop output
    mux_d = (state_d == ST_ON) ? (NB_MUX'(1) << index_d) : '0;
  end

  assign mux_out    = mux_q;
  assign mux_index  = index_q;
  assign slice_done = slice_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_mux_sequencer.sv
// Directed and random-invariant bench for mux_sequencer (NB_MUX=8, DEAD_CYCLES=4).
module tb_mux_sequencer;

  localparam int unsigned NB_MUX = 8;
  localparam int unsigned DEAD   = 4;
  localparam int unsigned IDX_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              position_sync;
  logic              column_ready;
  logic [NB_MUX-1:0] mux_out;
  logic [IDX_W-1:0]  mux_index;
  logic              slice_done;
  logic              overrun;

  int checks = 0;
  int fails  = 0;

  mux_sequencer #(.NB_MUX(NB_MUX), .DEAD_CYCLES(DEAD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .position_sync(position_sync),
    .column_ready(column_ready), .mux_out(mux_out), .mux_index(mux_index),
    .slice_done(slice_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse one input for a single edge
  task automatic pulse_cr();
    column_ready = 1'b1; step(); column_ready = 1'b0;
  endtask

  task automatic pulse_sync();
    position_sync = 1'b1; step(); position_sync = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; position_sync = 1'b0; column_ready = 1'b0;
    step(); step();
    chk("reset mux_out", 32'(mux_out), 32'h0);
    chk("reset mux_index", 32'(mux_index), 32'h0);
    chk("reset slice_done", 32'(slice_done), 32'h0);
    chk("reset overrun", 32'(overrun), 32'h0);
    #3 rst = 1'b0;
    step();
  endtask

  task automatic test_start();
    enable = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wait_sync idle mux", 32'(mux_out), 32'h0);
    end
    pulse_sync();
    for (int i = 0; i < 4; i++) begin
      chk("start dead mux", 32'(mux_out), 32'h0);
      step();
    end
    chk("start group0 mux", 32'(mux_out), 32'h01);
    chk("start group0 idx", 32'(mux_index), 32'h0);
  endtask

  task automatic test_stepping();
    int slices = 0;
    for (int k = 1; k <= 8; k++) begin
      for (int j = 0; j < 15; j++) step();
      chk("hold mux", 32'(mux_out), 32'(8'h01 << ((k - 1) % 8)));
      pulse_cr();
      for (int j = 0; j < 4; j++) begin
        chk("step dead mux", 32'(mux_out), 32'h0);
        chk("step slice_done", 32'(slice_done), 32'((k == 8) && (j == 0)));
        if (slice_done) slices++;
        step();
      end
      chk("step mux", 32'(mux_out), 32'(8'h01 << (k % 8)));
      chk("step idx", 32'(mux_index), 32'(k % 8));
    end
    chk("slice count", 32'(slices), 32'd1);
  endtask

  task automatic test_overrun();
    pulse_cr();
    step();
    pulse_cr();
    chk("overrun idx", 32'(mux_index), 32'h1);
    chk("overrun set", 32'(overrun), 32'h1);
    step();
    chk("overrun dead", 32'(mux_out), 32'h0);
    step();
    chk("overrun no reload mux", 32'(mux_out), 32'h02);
    step(); step();
    chk("overrun sticky", 32'(overrun), 32'h1);
    enable = 1'b0;
    step();
    chk("disable mux", 32'(mux_out), 32'h0);
    chk("disable overrun", 32'(overrun), 32'h0);
    chk("disable idx", 32'(mux_index), 32'h0);
  endtask

  task automatic test_sync_priority();
    enable = 1'b1;
    step();
    pulse_sync();
    for (int i = 0; i < 4; i++) step();
    for (int k = 1; k <= 5; k++) begin
      pulse_cr();
      for (int i = 0; i < 4; i++) step();
    end
    chk("pre idx5", 32'(mux_index), 32'h5);
    chk("pre mux5", 32'(mux_out), 32'h20);
    position_sync = 1'b1; column_ready = 1'b1;
    step();
    position_sync = 1'b0; column_ready = 1'b0;
    chk("resync idx", 32'(mux_index), 32'h0);
    chk("resync slice", 32'(slice_done), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("resync dead", 32'(mux_out), 32'h0);
      step();
    end
    chk("resync group0", 32'(mux_out), 32'h01);
  endtask

  task automatic test_async_reset();
    pulse_cr();
    for (int i = 0; i < 4; i++) step();
    chk("pre-rst mux", 32'(mux_out), 32'h02);
    #2 rst = 1'b1;
    #1;
    chk("async rst mux", 32'(mux_out), 32'h0);
    chk("async rst idx", 32'(mux_index), 32'h0);
    step();
    #3 rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("post-rst waits", 32'(mux_out), 32'h0);
    pulse_cr();
    chk("post-rst cr ignored", 32'(overrun), 32'h0);
    pulse_sync();
    for (int i = 0; i < 4; i++) begin
      chk("post-rst dead", 32'(mux_out), 32'h0);
      step();
    end
    chk("post-rst group0", 32'(mux_out), 32'h01);
  endtask

  task automatic test_random();
    logic [NB_MUX-1:0] prev = '0;
    int zero_run = 100;
    for (int c = 0; c < 4000; c++) begin
      enable        = ($urandom_range(0, 59) != 0);
      position_sync = ($urandom_range(0, 39) == 0);
      column_ready  = ($urandom_range(0, 7) == 0);
      step();
      chk("onehot", 32'($countones(mux_out) <= 1), 32'h1);
      if (mux_out != '0 && mux_out != prev) begin
        chk("dead gap", 32'((prev == '0) && (zero_run >= int'(DEAD))), 32'h1);
      end
      zero_run = (mux_out == '0) ? zero_run + 1 : 0;
      prev = mux_out;
    end
    position_sync = 1'b0; column_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_stepping();
    test_overrun();
    test_sync_priority();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
